// File: rtl/freq_gate_counter.sv
// freq_gate_counter
//   Gated edge counter. Synchronises the PLL lock flag and an asynchronous
//   signal under test. After lock has been stable for SETTLE_CYCLES, it counts
//   rising edges of sig_in over back-to-back windows of GATE_CYCLES clocks.
//   Each window ends in a one-cycle PUBLISH that hands the count to the
//   readout logic through a valid/ready handshake.
//   Frequency = freq_count * f_clk / GATE_CYCLES; scaling is done downstream.
//
// Ports
//   clk          in   measurement clock
//   rst_n        in   asynchronous active-low reset
//   pll_locked   in   PLL lock flag (asynchronous, 2-FF synchronised)
//   sig_in       in   signal under test (asynchronous, 2-FF sync + history FF)
//   result_ready in   consumer accepts the current result
//   freq_count   out  edge count of the last completed gate
//   result_valid out  freq_count holds an unconsumed result
//   overrun      out  an unconsumed result was overwritten
//   saturated    out  the count behind freq_count hit all-ones
//   meas_active  out  high while in GATE
module freq_gate_counter #(
  parameter int GATE_CYCLES   = 200000000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             sig_in,
  input  logic             result_ready,
  output logic [CNT_W-1:0] freq_count,
  output logic             result_valid,
  output logic             overrun,
  output logic             saturated,
  output logic             meas_active
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [GATE_W-1:0] GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_GATE      = 2'd2,
    ST_PUBLISH   = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_lock_s1;
  logic               r_lock_s2;
  logic               r_sig_s1;
  logic               r_sig_s2;
  logic               r_sig_s3;
  logic [SET_W-1:0]   r_settle_cnt;
  logic [GATE_W-1:0]  r_gate_cnt;
  logic [CNT_W-1:0]   r_edge_cnt;
  logic [CNT_W-1:0]   r_freq_count;
  logic               r_result_valid;
  logic               r_overrun;
  logic               r_saturated;
  logic               r_meas_active;

  logic               w_lock_s;
  logic               w_rise;
  logic [CNT_W-1:0]   w_edge_next;

  // Synchronisers; r_sig_s3 is the history flop used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
      r_sig_s1  <= 1'b0;
      r_sig_s2  <= 1'b0;
      r_sig_s3  <= 1'b0;
    end else begin
      r_lock_s1 <= pll_locked;
      r_lock_s2 <= r_lock_s1;
      r_sig_s1  <= sig_in;
      r_sig_s2  <= r_sig_s1;
      r_sig_s3  <= r_sig_s2;
    end
  end

  assign w_lock_s = r_lock_s2;
  assign w_rise   = r_sig_s2 & ~r_sig_s3;

  // Saturating increment: the counter sticks at all-ones.
  assign w_edge_next = (w_rise && (r_edge_cnt != CNT_MAX)) ? r_edge_cnt + 1'b1 : r_edge_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_WAIT_LOCK;
      r_settle_cnt   <= '0;
      r_gate_cnt     <= '0;
      r_edge_cnt     <= '0;
      r_freq_count   <= '0;
      r_result_valid <= 1'b0;
      r_overrun      <= 1'b0;
      r_saturated    <= 1'b0;
      r_meas_active  <= 1'b0;
    end else begin
      // Consumer handshake; a publish in the same cycle overrides this below.
      if (r_result_valid && result_ready) begin
        r_result_valid <= 1'b0;
        r_overrun      <= 1'b0;
      end

      // Lock loss aborts the measurement; the published result is kept.
      if ((r_state != ST_WAIT_LOCK) && !w_lock_s) begin
        r_state       <= ST_WAIT_LOCK;
        r_meas_active <= 1'b0;
      end else begin
        case (r_state)
          ST_WAIT_LOCK: begin
            if (w_lock_s) begin
              r_settle_cnt <= '0;
              r_state      <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (r_settle_cnt == SETTLE_LAST) begin
              r_gate_cnt    <= '0;
              r_edge_cnt    <= '0;
              r_meas_active <= 1'b1;
              r_state       <= ST_GATE;
            end else begin
              r_settle_cnt <= r_settle_cnt + 1'b1;
            end
          end
          ST_GATE: begin
            // An edge in the last gate cycle is still included.
            r_edge_cnt <= w_edge_next;
            if (r_gate_cnt == GATE_LAST) begin
              r_meas_active <= 1'b0;
              r_state       <= ST_PUBLISH;
            end else begin
              r_gate_cnt <= r_gate_cnt + 1'b1;
            end
          end
          ST_PUBLISH: begin
            // Rises here are dropped: one dead cycle per window.
            r_freq_count   <= r_edge_cnt;
            r_saturated    <= (r_edge_cnt == CNT_MAX);
            r_result_valid <= 1'b1;
            r_overrun      <= r_result_valid && !result_ready;
            r_gate_cnt     <= '0;
            r_edge_cnt     <= '0;
            r_meas_active  <= 1'b1;
            r_state        <= ST_GATE;
          end
          default: begin
            r_meas_active <= 1'b0;
            r_state       <= ST_WAIT_LOCK;
          end
        endcase
      end
    end
  end

  assign freq_count   = r_freq_count;
  assign result_valid = r_result_valid;
  assign overrun      = r_overrun;
  assign saturated    = r_saturated;
  assign meas_active  = r_meas_active;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Testbench for freq_gate_counter. Two instances (CNT_W=32 and CNT_W=4) share
// the same stimulus. Inputs are driven on the falling edge so every sampled
// value is known; the reference model derives gate windows and publish cycles
// from the lock history by arithmetic and counts rising edges of the sampled
// sig_in history over each window.
module tb_freq_gate_counter;

  localparam int G    = 100;
  localparam int S    = 8;
  localparam int HMAX = 8192;
  localparam int INF  = 1 << 30;

  logic        clk;
  logic        rst_n;
  logic        pll_locked;
  logic        sig_in;
  logic        result_ready;
  logic [31:0] freq_count;
  logic        result_valid;
  logic        overrun;
  logic        saturated;
  logic        meas_active;
  logic [3:0]  freq_count4;
  logic        result_valid4;
  logic        overrun4;
  logic        saturated4;
  logic        meas_active4;

  freq_gate_counter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .sig_in(sig_in),
    .result_ready(result_ready), .freq_count(freq_count),
    .result_valid(result_valid), .overrun(overrun), .saturated(saturated),
    .meas_active(meas_active)
  );

  freq_gate_counter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .sig_in(sig_in),
    .result_ready(result_ready), .freq_count(freq_count4),
    .result_valid(result_valid4), .overrun(overrun4), .saturated(saturated4),
    .meas_active(meas_active4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sampled input history: index n is the value seen at posedge n.
  bit lock_h [0:HMAX-1];
  bit sig_h  [0:HMAX-1];
  bit rdy_h  [0:HMAX-1];
  int cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int          ep_l   = -1;   // first cycle after leaving WAIT_LOCK
  int          ep_end = INF;  // first cycle back in WAIT_LOCK
  logic        exp_valid = 1'b0;
  logic        exp_overrun = 1'b0;
  logic [31:0] exp_count = '0;
  logic [31:0] exp_count4 = '0;
  logic        exp_sat = 1'b0;
  logic        exp_sat4 = 1'b0;
  logic        exp_active = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit in_run(input int x);
    return (ep_l >= 0) && (x >= ep_l) && (x < ep_end);
  endfunction

  function automatic bit is_gate(input int x);
    if (!in_run(x) || (x < ep_l + S)) return 1'b0;
    return ((x - ep_l - S) % (G + 1)) < G;
  endfunction

  // Cycle x is a PUBLISH that actually publishes (lock still seen high).
  function automatic bit is_pub(input int x);
    if (x < 1 || !in_run(x) || (x < ep_l + S)) return 1'b0;
    return (((x - ep_l - S) % (G + 1)) == G) && lock_h[x-1];
  endfunction

  // Rising edges of sig_in whose detection falls in the G gate cycles before p.
  function automatic int window_count(input int p);
    int c = 0;
    for (int m = p - G; m < p; m++)
      if (sig_h[m-1] && !sig_h[m-2]) c++;
    return c;
  endfunction

  task automatic model_step(input int n);
    int c;
    if (is_pub(n - 1)) begin
      c           = window_count(n - 1);
      exp_overrun = exp_valid && !rdy_h[n];
      exp_valid   = 1'b1;
      exp_count   = 32'(c);
      exp_sat     = (c >= 32'hFFFF_FFFF);
      exp_count4  = (c >= 15) ? 32'd15 : 32'(c);
      exp_sat4    = (c >= 15);
      $display("cyc %0d publish count=%0d count4=%0d overrun=%0d", n, c, exp_count4, exp_overrun);
    end else if (exp_valid && rdy_h[n]) begin
      exp_valid   = 1'b0;
      exp_overrun = 1'b0;
    end
    if (in_run(n)) begin
      if (ep_end == INF && !lock_h[n-1]) ep_end = n + 1;
    end else if (lock_h[n-1]) begin
      ep_l   = n + 1;
      ep_end = INF;
    end
    exp_active = is_gate(n);
  endtask

  task automatic compare_all();
    check_eq("meas_active",   32'(meas_active),   32'(exp_active));
    check_eq("result_valid",  32'(result_valid),  32'(exp_valid));
    check_eq("overrun",       32'(overrun),       32'(exp_overrun));
    check_eq("freq_count",    freq_count,         exp_count);
    check_eq("saturated",     32'(saturated),     32'(exp_sat));
    check_eq("meas_active4",  32'(meas_active4),  32'(exp_active));
    check_eq("result_valid4", 32'(result_valid4), 32'(exp_valid));
    check_eq("overrun4",      32'(overrun4),      32'(exp_overrun));
    check_eq("freq_count4",   32'(freq_count4),   exp_count4);
    check_eq("saturated4",    32'(saturated4),    32'(exp_sat4));
  endtask

  task automatic tick(input logic lk, input logic sg, input logic rd);
    if (cyc >= HMAX - 2) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, HMAX - 2);
      $fatal(1, "cycle budget exhausted");
    end
    @(negedge clk);
    pll_locked   = lk;
    sig_in       = sg;
    result_ready = rd;
    lock_h[cyc+1] = lk;
    sig_h[cyc+1]  = sg;
    rdy_h[cyc+1]  = rd;
    @(posedge clk);
    cyc++;
    #1;
    model_step(cyc);
    compare_all();
  endtask

  initial begin
    int ph;
    int seen;
    int hold;
    bit sv;
    bit found;

    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    sig_in       = 1'b0;
    result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compare_all();                       // reset state
    rst_n = 1'b1;

    // No lock: everything stays idle.
    for (int i = 0; i < 500; i++) tick(1'b0, 1'($urandom % 2), 1'($urandom % 2));

    // Lock, 10-cycle period, consumer always ready.
    ph = $urandom % 10;
    for (int i = 0; i < 450; i++) tick(1'b1, ((i + ph) % 10) < 5, 1'b1);

    // Consumer stalls: second publish overruns; then one ready pulse.
    for (int i = 0; i < 230; i++) tick(1'b1, ((i + ph) % 10) < 5, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);

    // Drop lock 50 cycles into a gate while a result is pending.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick(1'b1, ((i + ph) % 10) < 5, 1'b0);
      if (exp_active && ((cyc - ep_l - S) % (G + 1)) == 50) found = 1'b1;
    end
    check_eq("reach_gate_mid", 32'(found), 32'd1);
    for (int i = 0; i < 20; i++) tick(1'b0, (i % 10) < 5, 1'b0);
    for (int i = 0; i < 250; i++) tick(1'b1, (i % 10) < 5, 1'b1);

    // Toggle every cycle (saturates the 4-bit instance), then hold high.
    for (int i = 0; i < 230; i++) tick(1'b1, 1'(cyc % 2), 1'b1);
    for (int i = 0; i < 230; i++) tick(1'b1, 1'b1, 1'b1);

    // Ready asserted exactly in a PUBLISH cycle with a result pending.
    seen = 0;
    for (int i = 0; i < 400 && seen < 2; i++) begin
      tick(1'b1, (i % 7) < 3, 1'b0);
      if (is_pub(cyc)) seen++;
    end
    check_eq("reach_second_publish", 32'(seen), 32'd2);
    tick(1'b1, 1'b0, 1'b1);
    check_eq("pub_ready_valid",   32'(result_valid), 32'd1);
    check_eq("pub_ready_overrun", 32'(overrun),      32'd0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);

    // Random edge spacing and random consumer readiness.
    sv = 1'b0;
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        sv   = ~sv;
        hold = $urandom_range(1, 5);
      end
      hold--;
      tick(1'b1, sv, ($urandom % 4) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_gate_counter.md
# freq_gate_counter

Gated edge counter fed by the system PLL's measurement clock: it synchronises the PLL `locked` flag and an asynchronous signal under test. Once the PLL is stable, it counts rising edges of that signal over back-to-back gate windows of fixed length. Each result is published with a valid/ready handshake to the readout logic (SPI register file). Frequency = count × f_clk / GATE_CYCLES; scaling is done downstream.

## Interface
Parameters:
- `GATE_CYCLES`, 200000000, gate window length in `clk` cycles (1 s at 200 MHz); ≥ 2.
- `SETTLE_CYCLES`, 1024, cycles to wait after synchronised lock before the first gate; ≥ 1.
- `CNT_W`, 32, width of the edge count.

Ports:
- `clk`  in  1  measurement clock (PLL outclk_0).
- `rst_n`  in  1  asynchronous, active-low reset.
- `pll_locked`  in  1  PLL lock flag, asynchronous; 2-FF synchronised internally.
- `sig_in`  in  1  signal under test, asynchronous; 2-FF synchronised, plus one history FF.
- `result_ready`  in  1  consumer accepts the result.
- `freq_count`  out  CNT_W  edge count of the last completed gate.
- `result_valid`  out  1  `freq_count` holds an unconsumed result.
- `overrun`  out  1  an unconsumed result was overwritten.
- `saturated`  out  1  the count for the current result hit all-ones.
- `meas_active`  out  1  high while in GATE.

## Operation
- One clock only; one clock domain.
- Reset:
  - `rst_n` low asynchronously clears all flops.
  - All outputs reset to 0.
  - The FSM resets to WAIT_LOCK.
- Edge detection:
  - `rise = s2 & ~s3`, where s1/s2 form the synchroniser and s3 is the history flop.
  - A rise is counted only when asserted in a GATE cycle.
- FSM:
  - WAIT_LOCK: waits for `lock_s` = 1, then clears the settle counter and goes to SETTLE.
  - SETTLE: counts `SETTLE_CYCLES` cycles, then clears the gate and edge counters and goes to GATE.
  - GATE: lasts exactly `GATE_CYCLES` cycles.
    - The gate counter runs 0..GATE_CYCLES-1.
    - The edge counter increments on `rise`.
    - The gate counter is `$clog2(GATE_CYCLES)` bits wide.
    - In the last GATE cycle, an edge in that same cycle is included; the FSM then goes to PUBLISH.
  - PUBLISH: one cycle.
    - Loads `freq_count` and `saturated` from the final count.
    - Sets `result_valid` = 1.
    - Clears the counters and goes to GATE.
    - A rise during PUBLISH is not counted (1-cycle dead time per window).
- Any state other than WAIT_LOCK, when `lock_s` = 0: go to WAIT_LOCK next cycle.
  - The partial count is discarded.
  - `freq_count`, `result_valid`, `overrun` and `saturated` are unchanged.
- Saturation: the edge counter stops at 2^CNT_W−1; `saturated` is latched with the result.
- Handshake:
  - `result_valid & result_ready` in a cycle clears `result_valid` and `overrun` next cycle.
  - `freq_count` holds its value.
- Overrun:
  - PUBLISH with `result_valid` = 1 and `result_ready` = 0: new data overwrites the old, `result_valid` stays 1, `overrun` is set to 1.
  - PUBLISH with `result_valid` = 1 and `result_ready` = 1 in the same cycle: new data loads, `result_valid` stays 1, `overrun` is cleared to 0.
- `result_ready` without `result_valid` has no effect.

## Timing
- `pll_locked` rise to FSM leaving WAIT_LOCK: 2–3 cycles (synchroniser).
- `sig_in` rise to `rise` asserted: 2–3 cycles, depending on sampling phase.
- `rise` is high for 1 cycle per `sig_in` rising edge.
  - `sig_in` pulses shorter than one `clk` period may be missed.
  - Edges must be ≥ 2 cycles apart to be counted individually.
- First PUBLISH occurs `SETTLE_CYCLES + GATE_CYCLES` cycles after leaving WAIT_LOCK.
- Later publishes occur every `GATE_CYCLES + 1` cycles.
- `result_valid`, `freq_count`, `saturated` and `overrun` update on the clock edge that ends PUBLISH.
- `meas_active` is registered and high exactly during GATE cycles.

## Test plan
Parameters for the bench: GATE_CYCLES=100, SETTLE_CYCLES=8, CNT_W=32, unless noted.

1. Reset with `pll_locked` = 0 for 500 cycles -> all outputs 0; `meas_active` never rises.
2. `pll_locked` = 1; `sig_in` period 10 cycles; `result_ready` = 1 -> first result `freq_count` = 10 after ~110 cycles; each later result 10 (±1 allowed only on the first window); `overrun` = 0.
3. As 2, with `result_ready` held 0 -> first publish gives `result_valid` = 1, `overrun` = 0; second publish gives `overrun` = 1 with the new count. Pulse `result_ready` for 1 cycle -> `result_valid` = 0 and `overrun` = 0 next cycle.
4. Drop `pll_locked` 50 cycles into a gate -> no publish; outputs retain the previous result. Reassert -> `meas_active` returns after 2–3 + 8 cycles; next result is a full-window count of 10.
5. CNT_W=4; `sig_in` toggling every cycle (50 rises per gate) -> `freq_count` = 15, `saturated` = 1. Then `sig_in` constant 1 -> next result `freq_count` = 0, `saturated` = 0.
6. Assert `result_ready` in exactly the PUBLISH cycle while `result_valid` = 1 -> `result_valid` stays 1, `overrun` = 0, `freq_count` = new value.
